// File: rtl/axi4lite_reg_file.sv
// AXI4-Lite slave register file: REG_COUNT word registers with byte-strobe
// writes, independent AW/W capture, one outstanding write and read response.
// Optional macro AXIL_REGFILE_ERR_RESP_EN: out-of-range accesses answer SLVERR.
module axi4lite_reg_file #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_COUNT  = 16
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [ADDR_WIDTH-1:0]           s_axi_awaddr,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [2:0]                      s_axi_awprot,
  input  logic [DATA_WIDTH-1:0]           s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]         s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]           s_axi_araddr,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  input  logic [2:0]                      s_axi_arprot,
  output logic [DATA_WIDTH-1:0]           s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [REG_COUNT*DATA_WIDTH-1:0] regs_o,
  output logic [REG_COUNT-1:0]            wr_pulse_o
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFS    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REGFILE_ERR_RESP_EN
  localparam logic [1:0] RESP_BAD  = 2'b10;
`else
  localparam logic [1:0] RESP_BAD  = 2'b00;
`endif

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic                  aw_held;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  logic                  w_held;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic [IDX_W-1:0]      aw_idx;
  logic                  aw_in_range;
  logic [IDX_W-1:0]      ar_idx;
  logic                  ar_in_range;

  // Protection attributes carry no meaning for this register file.
  logic unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot};

  assign s_axi_awready = !aw_held;
  assign s_axi_wready  = !w_held;
  assign s_axi_arready = !s_axi_rvalid || s_axi_rready;

  assign aw_hs  = s_axi_awvalid && s_axi_awready;
  assign w_hs   = s_axi_wvalid && s_axi_wready;
  assign ar_hs  = s_axi_arvalid && s_axi_arready;
  assign commit = aw_held && w_held && !s_axi_bvalid;

  // Word index decode; byte-offset bits are ignored, any high bit set is out of range.
  assign aw_idx      = IDX_W'(aw_addr >> OFS);
  assign aw_in_range = (aw_addr >> OFS) < ADDR_WIDTH'(REG_COUNT);
  assign ar_idx      = IDX_W'(s_axi_araddr >> OFS);
  assign ar_in_range = (s_axi_araddr >> OFS) < ADDR_WIDTH'(REG_COUNT);

  // Write address and data holding registers, released together on commit.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_held <= 1'b0;
      aw_addr <= '0;
      w_held  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      if (commit) begin
        aw_held <= 1'b0;
      end else if (aw_hs) begin
        aw_held <= 1'b1;
        aw_addr <= s_axi_awaddr;
      end
      if (commit) begin
        w_held <= 1'b0;
      end else if (w_hs) begin
        w_held <= 1'b1;
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end
    end
  end

  // Register array update with byte-strobe merge, plus the per-register write pulse.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < int'(REG_COUNT); i++) regs[i] <= '0;
      wr_pulse_o <= '0;
    end else begin
      wr_pulse_o <= '0;
      if (commit && aw_in_range) begin
        wr_pulse_o[aw_idx] <= 1'b1;
        for (int k = 0; k < int'(STRB_W); k++) begin
          if (w_strb[k]) regs[aw_idx][k*8 +: 8] <= w_data[k*8 +: 8];
        end
      end
    end
  end

  // Write response: raised on commit, held until accepted.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
    end else if (commit) begin
      s_axi_bvalid <= 1'b1;
      s_axi_bresp  <= aw_in_range ? RESP_OKAY : RESP_BAD;
    end else if (s_axi_bready) begin
      s_axi_bvalid <= 1'b0;
    end
  end

  // Read response: one cycle after the AR handshake, held while rready is low.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= ar_in_range ? regs[ar_idx] : '0;
      s_axi_rresp  <= ar_in_range ? RESP_OKAY : RESP_BAD;
    end else if (s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

  // Flat export of the register contents.
  for (genvar g = 0; g < int'(REG_COUNT); g++) begin : g_export
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule
